// File: rtl/alu_pkg.sv
// Shared ALU operation codes, RV32I opcode/funct7 constants and the funct3 decode helper.
// Used by alu_issue and by the ALU itself.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } aluOp_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Base-encoding funct3 mapping shared by OP and OP-IMM.
  function automatic aluOp_t f3ToAluOp(input logic [2:0] f3);
    aluOp_t op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// Generic valid/ready register slice. Defining ALU_ISSUE_SKID_EN adds a one-entry
// skid behind the output register so the upstream ready comes from a flop.
module alu_issue_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

`ifdef ALU_ISSUE_SKID_EN
  logic         r_skValid;
  logic [W-1:0] r_skData;

  assign o_ready = !r_skValid;

  // A held skid entry always refills the output register before new input is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_skValid <= 1'b0;
      r_skData  <= '0;
    end else if (!r_valid || i_ready) begin
      if (r_skValid) begin
        r_valid   <= 1'b1;
        r_data    <= r_skData;
        r_skValid <= 1'b0;
      end else begin
        r_valid <= i_valid;
        if (i_valid) r_data <= i_data;
      end
    end else if (i_valid && !r_skValid) begin
      r_skValid <= 1'b1;
      r_skData  <= i_data;
    end
  end
`else
  assign o_ready = !r_valid || i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end
`endif

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/alu_issue.sv
// RV32I decode/issue stage producing ALU operands and operation code behind a register slice.
// Optional feature macro: ALU_ISSUE_SKID_EN (skid buffer, registered instReady).
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_instValid,
  output logic            o_instReady,
  input  logic [31:0]     i_instruction,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1Data,
  input  logic [XLEN-1:0] i_rs2Data,
  output logic            o_opValid,
  input  logic            i_opReady,
  output logic [XLEN-1:0] o_in1,
  output logic [XLEN-1:0] o_in2,
  output logic [3:0]      o_operation,
  output logic            o_illegal
);

  localparam int PW = 2 * XLEN + 5;

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_immI;
  logic [XLEN-1:0] w_immS;
  logic [XLEN-1:0] w_immU;
  logic [XLEN-1:0] w_shamt;
  logic [XLEN-1:0] w_in1;
  logic [XLEN-1:0] w_in2;
  aluOp_t          w_op;
  logic            w_illegal;
  logic [PW-1:0]   w_inData;
  logic [PW-1:0]   w_outData;
  logic            w_unused_rs1Idx;

  assign w_opcode        = i_instruction[6:0];
  assign w_f3            = i_instruction[14:12];
  assign w_f7            = i_instruction[31:25];
  assign w_immI          = {{(XLEN-12){i_instruction[31]}}, i_instruction[31:20]};
  assign w_immS          = {{(XLEN-12){i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
  assign w_immU          = {i_instruction[31:12], 12'b0};
  assign w_shamt         = {{(XLEN-5){1'b0}}, i_instruction[24:20]};
  assign w_unused_rs1Idx = ^i_instruction[19:15];

  always_comb begin
    w_illegal = 1'b0;
    w_op      = ALU_ADD;
    w_in1     = i_rs1Data;
    w_in2     = i_rs2Data;
    case (w_opcode)
      OPC_OP: begin
        if (w_f7 == F7_BASE)                       w_op = f3ToAluOp(w_f3);
        else if (w_f7 == F7_ALT && w_f3 == 3'b000) w_op = ALU_SUB;
        else if (w_f7 == F7_ALT && w_f3 == 3'b101) w_op = ALU_SRA;
        else                                       w_illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        w_in2 = w_immI;
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          w_in2 = w_shamt;
          if (w_f7 == F7_BASE)                       w_op = f3ToAluOp(w_f3);
          else if (w_f7 == F7_ALT && w_f3 == 3'b101) w_op = ALU_SRA;
          else                                       w_illegal = 1'b1;
        end else begin
          w_op = f3ToAluOp(w_f3);
        end
      end
      OPC_LUI: begin
        w_in1 = '0;
        w_in2 = w_immU;
      end
      OPC_AUIPC: begin
        w_in1 = i_pc;
        w_in2 = w_immU;
      end
      OPC_LOAD:  w_in2 = w_immI;
      OPC_STORE: w_in2 = w_immS;
      OPC_BRANCH: begin
        case (w_f3[2:1])
          2'b00:   w_op = ALU_SUB;
          2'b10:   w_op = ALU_SLT;
          2'b11:   w_op = ALU_SLTU;
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
    // Illegal instructions still issue, but with a harmless zero ADD.
    if (w_illegal) begin
      w_in1 = '0;
      w_in2 = '0;
      w_op  = ALU_ADD;
    end
  end

  assign w_inData = {w_illegal, w_op, w_in1, w_in2};

  alu_issue_skid #(
    .W(PW)
  ) u_slice (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_instValid),
    .o_ready (o_instReady),
    .i_data  (w_inData),
    .o_valid (o_opValid),
    .i_ready (i_opReady),
    .o_data  (w_outData)
  );

  assign {o_illegal, o_operation, o_in1, o_in2} = w_outData;

endmodule
